// File: rtl/ac97_command_sequencer_if.sv
// Command bundle between the sequencer, the AC97 link controller (done/Register/command/validate)
// and the user write requester (UserWrite/UserRegister/UserCommand/UserBusy).
interface ac97_command_sequencer_if;
   logic        done;
   logic        UserWrite;
   logic [7:0]  UserRegister;
   logic [15:0] UserCommand;
   logic        UserBusy;
   logic        InitDone;
   logic [7:0]  Register;
   logic [15:0] command;
   logic        validate;

   modport master (
      input  done, UserWrite, UserRegister, UserCommand,
      output UserBusy, InitDone, Register, command, validate
   );

   modport slave (
      output done, UserWrite, UserRegister, UserCommand,
      input  UserBusy, InitDone, Register, command, validate
   );
endinterface

// File: rtl/ac97_command_sequencer.sv
// AC97 command source: settle, six-entry codec init table, then one-shot user writes (AC97_USER_WRITE_EN);
// outputs move one clock after each done rise, one command per frame, UserWrite ignored while UserBusy.
module ac97_command_sequencer #(
   parameter int unsigned SETTLE_FRAMES = 16
) (
   input  logic                            AC97BitClock,
   input  logic                            Rst,
   ac97_command_sequencer_if.master        bus
);
   typedef enum logic [1:0] {S_WAIT, S_INIT, S_IDLE, S_USER} state_t;

   state_t      state;
   logic        doneQ;
   logic        frameEdge;
   logic [7:0]  frameCnt;
   logic [2:0]  initIdx;
   logic [7:0]  tabRegister;
   logic [15:0] tabCommand;
   logic [7:0]  reqRegister;
   logic [15:0] reqCommand;
   logic        userPending;

   assign frameEdge = bus.done & ~doneQ;

   always_comb begin
      tabRegister = 8'h00;
      tabCommand  = 16'h0000;
      case (initIdx)
         3'd1: tabRegister = 8'h02;
         3'd2: tabRegister = 8'h04;
         3'd3: begin
            tabRegister = 8'h18;
            tabCommand  = 16'h0808;
         end
         3'd4: tabRegister = 8'h1A;
         3'd5: tabRegister = 8'h1C;
         default: ;
      endcase
   end

`ifdef AC97_USER_WRITE_EN
   logic unusedRegBit;
   assign unusedRegBit = bus.UserRegister[7];
   assign userPending  = bus.UserBusy;

   // Busy is still high on the completing edge, so that edge can never capture.
   always_ff @(posedge AC97BitClock or posedge Rst) begin
      if (Rst) begin
         bus.UserBusy <= 1'b0;
         reqRegister  <= 8'h00;
         reqCommand   <= 16'h0000;
      end else if (frameEdge && state == S_USER) begin
         bus.UserBusy <= 1'b0;
      end else if (bus.UserWrite && !bus.UserBusy) begin
         bus.UserBusy <= 1'b1;
         reqRegister  <= {1'b0, bus.UserRegister[6:0]};
         reqCommand   <= bus.UserCommand;
      end
   end
`else
   logic unusedUser;
   assign unusedUser   = ^{bus.UserWrite, bus.UserRegister, bus.UserCommand};
   assign userPending  = 1'b0;
   assign bus.UserBusy = 1'b0;
   assign reqRegister  = 8'h00;
   assign reqCommand   = 16'h0000;
`endif

   always_ff @(posedge AC97BitClock or posedge Rst) begin
      if (Rst) begin
         state        <= S_WAIT;
         doneQ        <= 1'b0;
         frameCnt     <= 8'd0;
         initIdx      <= 3'd0;
         bus.Register <= 8'h00;
         bus.command  <= 16'h0000;
         bus.validate <= 1'b0;
         bus.InitDone <= 1'b0;
      end else begin
         doneQ <= bus.done;
         if (frameEdge) begin
            unique case (state)
               S_WAIT: begin
                  frameCnt <= frameCnt + 8'd1;
                  if (frameCnt == 8'(SETTLE_FRAMES - 1)) begin
                     bus.Register <= tabRegister;
                     bus.command  <= tabCommand;
                     bus.validate <= 1'b1;
                     initIdx      <= 3'd1;
                     state        <= S_INIT;
                  end
               end
               S_INIT: begin
                  // initIdx 6 means entry 5 has just had its frame
                  if (initIdx == 3'd6) begin
                     bus.InitDone <= 1'b1;
                     if (userPending) begin
                        bus.Register <= reqRegister;
                        bus.command  <= reqCommand;
                        bus.validate <= 1'b1;
                        state        <= S_USER;
                     end else begin
                        bus.Register <= 8'h00;
                        bus.command  <= 16'h0000;
                        bus.validate <= 1'b0;
                        state        <= S_IDLE;
                     end
                  end else begin
                     bus.Register <= tabRegister;
                     bus.command  <= tabCommand;
                     initIdx      <= initIdx + 3'd1;
                  end
               end
               S_IDLE: begin
                  if (userPending) begin
                     bus.Register <= reqRegister;
                     bus.command  <= reqCommand;
                     bus.validate <= 1'b1;
                     state        <= S_USER;
                  end else begin
                     bus.Register <= 8'h00;
                     bus.command  <= 16'h0000;
                     bus.validate <= 1'b0;
                  end
               end
               S_USER: begin
                  bus.Register <= 8'h00;
                  bus.command  <= 16'h0000;
                  bus.validate <= 1'b0;
                  state        <= S_IDLE;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_ac97_command_sequencer.sv
// Bench for ac97_command_sequencer: 256-cycle AC97 frames, frame-level reference model, random user writes.
module tb_ac97_command_sequencer;
   localparam int S = 4;
`ifdef AC97_USER_WRITE_EN
   localparam bit USER_EN = 1'b1;
`else
   localparam bit USER_EN = 1'b0;
`endif

   logic AC97BitClock = 1'b0;
   logic Rst = 1'b1;
   ac97_command_sequencer_if ifc();

   ac97_command_sequencer #(.SETTLE_FRAMES(S)) dut (
      .AC97BitClock (AC97BitClock),
      .Rst          (Rst),
      .bus          (ifc.master)
   );

   always #5 AC97BitClock = ~AC97BitClock;

   wire [26:0] obs_vec = {ifc.InitDone, ifc.UserBusy, ifc.validate, ifc.Register, ifc.command};

   int checks = 0;
   int errors = 0;
   int fcnt, last_fc, edges;
   bit m_busy, m_inflight, e_init, e_val;
   logic [7:0]  e_reg, m_reg;
   logic [15:0] e_cmd, m_cmd;
   logic [7:0]  init_reg [6] = '{8'h00, 8'h02, 8'h04, 8'h18, 8'h1A, 8'h1C};
   logic [15:0] init_cmd [6] = '{16'h0000, 16'h0000, 16'h0000, 16'h0808, 16'h0000, 16'h0000};

   function automatic logic [26:0] expv();
      return {e_init, m_busy, e_val, e_reg, e_cmd};
   endfunction

   task automatic do_reset();
      Rst = 1'b1;
      ifc.done = 1'b0;
      ifc.UserWrite = 1'b0;
      ifc.UserRegister = 8'h00;
      ifc.UserCommand = 16'h0000;
      repeat (3) @(posedge AC97BitClock);
      #1;
      edges = 0; m_busy = 0; m_inflight = 0;
      e_init = 0; e_val = 0; e_reg = 8'h00; e_cmd = 16'h0000;
      m_reg = 8'h00; m_cmd = 16'h0000;
      fcnt = 2;
      Rst = 1'b0;
   endtask

   // One clock of stimulus plus the frame-level model; done is high on counters 128..255 and 0..1.
   task automatic run_cycle(input bit uw, input logic [7:0] ur, input logic [15:0] uc);
      bit old_busy;
      ifc.done = (fcnt >= 128) || (fcnt < 2);
      ifc.UserWrite = uw;
      ifc.UserRegister = ur;
      ifc.UserCommand = uc;
      old_busy = m_busy;
      if (fcnt == 128) begin
         edges++;
         if (edges < S) begin
            e_val = 0; e_reg = 8'h00; e_cmd = 16'h0000;
         end else if (edges < S + 6) begin
            e_val = 1; e_reg = init_reg[edges - S]; e_cmd = init_cmd[edges - S];
         end else begin
            e_init = 1;
            if (m_inflight) begin
               m_inflight = 0; m_busy = 0;
               e_val = 0; e_reg = 8'h00; e_cmd = 16'h0000;
            end else if (old_busy) begin
               m_inflight = 1;
               e_val = 1; e_reg = m_reg; e_cmd = m_cmd;
            end else begin
               e_val = 0; e_reg = 8'h00; e_cmd = 16'h0000;
            end
         end
      end
      if (USER_EN && uw && !old_busy) begin
         m_busy = 1;
         m_reg = {1'b0, ur[6:0]};
         m_cmd = uc;
      end
      @(posedge AC97BitClock);
      #1;
      last_fc = fcnt;
      fcnt = (fcnt + 1) % 256;
      ifc.UserWrite = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge AC97BitClock);
      #1;
      ifc.done = 1'b1;
      ifc.UserWrite = 1'b1;
      @(posedge AC97BitClock);
      #1;
      checks++;
      if (obs_vec !== 27'd0) begin
         errors++;
         $display("FAIL reset_held got=%h want=%h", obs_vec, 27'd0);
      end
      do_reset();
      checks++;
      if (obs_vec !== 27'd0) begin
         errors++;
         $display("FAIL reset_release got=%h want=%h", obs_vec, 27'd0);
      end
   endtask

   task automatic test_init_sequence();
      bit reached = 0;
      for (int g = 0; g < 256 * 14; g++) begin
         run_cycle(1'b0, 8'h00, 16'h0000);
         if (last_fc == 127 || last_fc == 128 || last_fc == 200) begin
            checks++;
            if (obs_vec !== expv()) begin
               errors++;
               $display("FAIL init_seq edge=%0d fc=%0d got=%h want=%h", edges, last_fc, obs_vec, expv());
            end
         end
         if (last_fc == 200 && edges == S - 1) begin
            checks++;
            if (ifc.validate !== 1'b0) begin
               errors++;
               $display("FAIL init_settle_validate got=%b want=0", ifc.validate);
            end
         end
         if (last_fc == 200 && edges == S + 3) begin
            checks++;
            if ({ifc.validate, ifc.Register, ifc.command} !== {1'b1, 8'h18, 16'h0808}) begin
               errors++;
               $display("FAIL init_entry3 got=%b/%h/%h want=1/18/0808", ifc.validate, ifc.Register, ifc.command);
            end
         end
         if (last_fc == 200 && edges == S + 5) begin
            checks++;
            if ({ifc.InitDone, ifc.validate, ifc.Register} !== {1'b0, 1'b1, 8'h1C}) begin
               errors++;
               $display("FAIL init_entry5 got=%b/%b/%h want=0/1/1c", ifc.InitDone, ifc.validate, ifc.Register);
            end
         end
         if (last_fc == 200 && edges == S + 6) begin
            checks++;
            if ({ifc.InitDone, ifc.validate} !== 2'b10) begin
               errors++;
               $display("FAIL init_done got=%b/%b want=1/0", ifc.InitDone, ifc.validate);
            end
         end
         if (last_fc == 200 && edges == S + 7) begin
            reached = 1;
            break;
         end
      end
      if (!reached) begin
         checks++; errors++;
         $display("FAIL init_seq timeout edges=%0d want=%0d", edges, S + 7);
      end
   endtask

   task automatic test_user_write();
      int e0, at;
      bit sent, reached, uw;
      logic [7:0] ur;
      logic [15:0] uc;
      logic [24:0] want;
      for (int it = 0; it < 5; it++) begin
         e0 = edges;
         at = (200 + $urandom_range(1, 176)) % 256;
         ur = (it == 0) ? 8'h85 : 8'($urandom);
         uc = (it == 0) ? 16'h1234 : 16'($urandom);
         want = USER_EN ? {1'b1, 1'b0, ur[6:0], uc} : 25'd0;
         sent = 0;
         reached = 0;
         for (int g = 0; g < 1200; g++) begin
            uw = !sent && (fcnt == at);
            sent = sent | uw;
            run_cycle(uw, ur, uc);
            if (uw || last_fc == 127 || last_fc == 128 || last_fc == 200) begin
               checks++;
               if (obs_vec !== expv()) begin
                  errors++;
                  $display("FAIL user_write it=%0d fc=%0d got=%h want=%h", it, last_fc, obs_vec, expv());
               end
            end
            if (last_fc == 200 && edges == e0 + 1) begin
               checks++;
               if ({ifc.validate, ifc.Register, ifc.command} !== want) begin
                  errors++;
                  $display("FAIL user_write_frame it=%0d got=%h want=%h", it, {ifc.validate, ifc.Register, ifc.command}, want);
               end
            end
            if (last_fc == 200 && edges == e0 + 2) begin
               checks++;
               if ({ifc.UserBusy, ifc.validate} !== 2'b00) begin
                  errors++;
                  $display("FAIL user_write_clear it=%0d got=%b%b want=00", it, ifc.UserBusy, ifc.validate);
               end
               reached = 1;
               break;
            end
         end
         if (!reached) begin
            checks++; errors++;
            $display("FAIL user_write timeout it=%0d", it);
         end
      end
   endtask

   task automatic test_busy_ignore();
      int e0;
      bit reached = 0;
      bit uw;
      logic [7:0] ra, rb, ur;
      logic [15:0] ca, cb, uc;
      logic [23:0] want;
      e0 = edges;
      ra = 8'($urandom); ca = 16'($urandom);
      rb = ra ^ 8'h3C; cb = ca ^ 16'hA55A;
      want = USER_EN ? {1'b0, ra[6:0], ca} : 24'd0;
      for (int g = 0; g < 800; g++) begin
         uw = (edges == e0) && (fcnt == 210 || fcnt == 20);
         ur = (fcnt == 210) ? ra : rb;
         uc = (fcnt == 210) ? ca : cb;
         run_cycle(uw, ur, uc);
         if (uw || last_fc == 127 || last_fc == 128 || last_fc == 200) begin
            checks++;
            if (obs_vec !== expv()) begin
               errors++;
               $display("FAIL busy_ignore fc=%0d got=%h want=%h", last_fc, obs_vec, expv());
            end
         end
         if (last_fc == 200 && edges == e0 + 1) begin
            checks++;
            if ({ifc.Register, ifc.command} !== want) begin
               errors++;
               $display("FAIL busy_ignore_frame got=%h want=%h", {ifc.Register, ifc.command}, want);
            end
         end
         if (last_fc == 200 && edges == e0 + 2) begin
            reached = 1;
            break;
         end
      end
      if (!reached) begin
         checks++; errors++;
         $display("FAIL busy_ignore timeout");
      end
   endtask

   task automatic test_edge_coincident();
      int e0;
      bit reached = 0;
      bit uw;
      logic [7:0] ur;
      logic [15:0] uc;
      e0 = edges;
      ur = 8'($urandom); uc = 16'($urandom);
      for (int g = 0; g < 1000; g++) begin
         uw = (edges == e0) && (fcnt == 128);
         run_cycle(uw, ur, uc);
         if (uw || last_fc == 127 || last_fc == 128 || last_fc == 200) begin
            checks++;
            if (obs_vec !== expv()) begin
               errors++;
               $display("FAIL edge_coincident fc=%0d got=%h want=%h", last_fc, obs_vec, expv());
            end
         end
         if (last_fc == 200 && edges == e0 + 1) begin
            checks++;
            if ({ifc.UserBusy, ifc.validate} !== {USER_EN, 1'b0}) begin
               errors++;
               $display("FAIL edge_coincident_defer got=%b%b want=%b0", ifc.UserBusy, ifc.validate, USER_EN);
            end
         end
         if (last_fc == 200 && edges == e0 + 2) begin
            checks++;
            if (ifc.validate !== USER_EN) begin
               errors++;
               $display("FAIL edge_coincident_issue got=%b want=%b", ifc.validate, USER_EN);
            end
         end
         if (last_fc == 200 && edges == e0 + 3) begin
            reached = 1;
            break;
         end
      end
      if (!reached) begin
         checks++; errors++;
         $display("FAIL edge_coincident timeout");
      end
   endtask

   task automatic test_back_to_back();
      int e0;
      bit reached = 0;
      bit uw;
      logic [7:0] ra, rc, rd, ur;
      logic [15:0] ca, cc, cd, uc;
      logic [23:0] want;
      e0 = edges;
      ra = 8'($urandom); ca = 16'($urandom);
      rc = 8'($urandom); cc = 16'($urandom);
      rd = rc ^ 8'h5A;   cd = cc ^ 16'hFFFF;
      want = USER_EN ? {1'b0, rd[6:0], cd} : 24'd0;
      for (int g = 0; g < 1300; g++) begin
         uw = 1'b0; ur = ra; uc = ca;
         if (edges == e0 && fcnt == 220) uw = 1'b1;
         if (edges == e0 + 1 && fcnt == 128) begin uw = 1'b1; ur = rc; uc = cc; end
         if (edges == e0 + 2 && fcnt == 129) begin uw = 1'b1; ur = rd; uc = cd; end
         run_cycle(uw, ur, uc);
         if (uw || last_fc == 127 || last_fc == 128 || last_fc == 200) begin
            checks++;
            if (obs_vec !== expv()) begin
               errors++;
               $display("FAIL back_to_back fc=%0d got=%h want=%h", last_fc, obs_vec, expv());
            end
         end
         if (last_fc == 200 && edges == e0 + 3) begin
            checks++;
            if ({ifc.Register, ifc.command} !== want) begin
               errors++;
               $display("FAIL back_to_back_second got=%h want=%h", {ifc.Register, ifc.command}, want);
            end
         end
         if (last_fc == 200 && edges == e0 + 4) begin
            reached = 1;
            break;
         end
      end
      if (!reached) begin
         checks++; errors++;
         $display("FAIL back_to_back timeout");
      end
   endtask

   task automatic test_init_request();
      bit reached = 0;
      bit uw;
      logic [7:0] ur;
      logic [15:0] uc;
      logic [25:0] want;
      do_reset();
      ur = 8'($urandom); uc = 16'($urandom);
      want = USER_EN ? {1'b1, 1'b1, 1'b0, ur[6:0], uc} : {1'b1, 25'd0};
      for (int g = 0; g < 256 * 15; g++) begin
         uw = (edges == S + 2) && (fcnt == 200);
         run_cycle(uw, ur, uc);
         if (uw || last_fc == 127 || last_fc == 128 || last_fc == 200) begin
            checks++;
            if (obs_vec !== expv()) begin
               errors++;
               $display("FAIL init_request edge=%0d fc=%0d got=%h want=%h", edges, last_fc, obs_vec, expv());
            end
         end
         if (last_fc == 200 && edges == S + 5) begin
            checks++;
            if (ifc.Register !== 8'h1C) begin
               errors++;
               $display("FAIL init_request_entry5 got=%h want=1c", ifc.Register);
            end
         end
         if (last_fc == 200 && edges == S + 6) begin
            checks++;
            if ({ifc.InitDone, ifc.validate, ifc.Register, ifc.command} !== want) begin
               errors++;
               $display("FAIL init_request_issue got=%h want=%h", {ifc.InitDone, ifc.validate, ifc.Register, ifc.command}, want);
            end
         end
         if (last_fc == 200 && edges == S + 8) begin
            reached = 1;
            break;
         end
      end
      if (!reached) begin
         checks++; errors++;
         $display("FAIL init_request timeout");
      end
   endtask

   task automatic test_reset_mid();
      bit reached = 0;
      bit uw;
      logic [7:0] ur;
      logic [15:0] uc;
      do_reset();
      ur = 8'($urandom); uc = 16'($urandom);
      for (int g = 0; g < 256 * 10; g++) begin
         uw = (edges == S + 1) && (fcnt == 200);
         run_cycle(uw, ur, uc);
         if (uw || last_fc == 128 || last_fc == 200) begin
            checks++;
            if (obs_vec !== expv()) begin
               errors++;
               $display("FAIL reset_mid_pre fc=%0d got=%h want=%h", last_fc, obs_vec, expv());
            end
         end
         if (last_fc == 200 && edges == S + 3) begin
            reached = 1;
            break;
         end
      end
      checks++;
      if (!reached || ifc.Register !== 8'h18) begin
         errors++;
         $display("FAIL reset_mid_entry3 got=%h want=18", ifc.Register);
      end
      #2;
      Rst = 1'b1;
      #1;
      checks++;
      if (obs_vec !== 27'd0) begin
         errors++;
         $display("FAIL reset_mid_async got=%h want=%h", obs_vec, 27'd0);
      end
      do_reset();
      reached = 0;
      for (int g = 0; g < 256 * 13; g++) begin
         run_cycle(1'b0, 8'h00, 16'h0000);
         if (last_fc == 127 || last_fc == 128 || last_fc == 200) begin
            checks++;
            if (obs_vec !== expv()) begin
               errors++;
               $display("FAIL reset_mid_post edge=%0d fc=%0d got=%h want=%h", edges, last_fc, obs_vec, expv());
            end
         end
         if (last_fc == 200 && edges == S + 1) begin
            checks++;
            if ({ifc.validate, ifc.Register} !== {1'b1, 8'h02}) begin
               errors++;
               $display("FAIL reset_mid_entry1 got=%b/%h want=1/02", ifc.validate, ifc.Register);
            end
         end
         if (last_fc == 200 && edges == S + 6) begin
            checks++;
            if ({ifc.InitDone, ifc.UserBusy, ifc.validate} !== 3'b100) begin
               errors++;
               $display("FAIL reset_mid_discard got=%b%b%b want=100", ifc.InitDone, ifc.UserBusy, ifc.validate);
            end
         end
         if (last_fc == 200 && edges == S + 7) begin
            reached = 1;
            break;
         end
      end
      if (!reached) begin
         checks++; errors++;
         $display("FAIL reset_mid timeout");
      end
   endtask

   initial begin
      ifc.done = 1'b0;
      ifc.UserWrite = 1'b0;
      ifc.UserRegister = 8'h00;
      ifc.UserCommand = 16'h0000;
      test_reset();
      test_init_sequence();
      test_user_write();
      test_busy_ignore();
      test_edge_coincident();
      test_back_to_back();
      test_init_request();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end
endmodule
